// File: rtl/entity_slot_scheduler.sv
// entity_slot_scheduler: frame-synchronous loader for the DCU's nine entity slots
//
// Game logic writes entity words into a shadow bank through a two-requester
// round-robin arbiter. At the commit point the shadow bank is copied into the
// active registers one slot per cycle, so the DCU never sees a half-updated frame.
//
// Ports:
//   clk                      pixel clock
//   reset                    synchronous, active-high
//   counter_V, counter_H     VGA sync counters (commit trigger)
//   req_{a,b}_valid          write request
//   req_{a,b}_slot           target slot, 1..9 are real slots
//   req_{a,b}_entity         entity word {ID[13:10], orientation[9:8], tile[7:0]}
//   req_{a,b}_ready          write accepted when high together with valid
//   entity_1 .. entity_7     active non-flipped slots
//   entity_8_Flip/9_Flip     active flipped slots (copied as-is, DCU flips)
//   frame_commit             one-cycle pulse after the last slot is copied
//   bad_slot                 sticky: out-of-range slot handshake since last commit
//
// Build option: define SLOT_AUTOCLEAR_EN to empty each shadow slot as it is
// committed, so entities not rewritten during a frame vanish at the next commit.
module entity_slot_scheduler #(
   parameter logic [9:0]  COMMIT_LINE  = 10'd480,
   parameter logic [9:0]  COMMIT_PIXEL = 10'd0,
   parameter logic [13:0] UNUSED_WORD  = 14'h3C00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  counter_V,
   input  logic [9:0]  counter_H,
   input  logic        req_a_valid,
   input  logic [3:0]  req_a_slot,
   input  logic [13:0] req_a_entity,
   output logic        req_a_ready,
   input  logic        req_b_valid,
   input  logic [3:0]  req_b_slot,
   input  logic [13:0] req_b_entity,
   output logic        req_b_ready,
   output logic [13:0] entity_1,
   output logic [13:0] entity_2,
   output logic [13:0] entity_3,
   output logic [13:0] entity_4,
   output logic [13:0] entity_5,
   output logic [13:0] entity_6,
   output logic [13:0] entity_7,
   output logic [13:0] entity_8_Flip,
   output logic [13:0] entity_9_Flip,
   output logic        frame_commit,
   output logic        bad_slot
);
   typedef enum logic {ACCEPT, COMMIT} state_t;
   state_t      state, state_next;
   logic [3:0]  ci, ci_next;
   logic        prefer_a;
   logic [13:0] shadow [1:9];
   logic [13:0] active [1:9];
   logic        grant_a, grant_b, hs, hs_ok, last_copy;
   logic [3:0]  hs_slot;
   logic [13:0] hs_entity;

   // Readies are held low during reset so no write can slip in on the reset edge.
   always_comb begin
      state_next  = state;
      ci_next     = ci;
      grant_a     = 1'b0;
      grant_b     = 1'b0;
      req_a_ready = 1'b0;
      req_b_ready = 1'b0;
      last_copy   = 1'b0;
      if (!reset) begin
         if (state == ACCEPT) begin
            grant_a     = req_a_valid && (!req_b_valid || prefer_a);
            grant_b     = req_b_valid && (!req_a_valid || !prefer_a);
            req_a_ready = grant_a || !(req_a_valid || req_b_valid);
            req_b_ready = grant_b || !(req_a_valid || req_b_valid);
            if (counter_V == COMMIT_LINE && counter_H == COMMIT_PIXEL) begin
               state_next = COMMIT;
               ci_next    = 4'd1;
            end
         end else begin
            last_copy  = (ci == 4'd9);
            state_next = last_copy ? ACCEPT : COMMIT;
            ci_next    = last_copy ? 4'd1 : ci + 4'd1;
         end
      end
   end

   assign hs        = grant_a || grant_b;
   assign hs_slot   = grant_b ? req_b_slot : req_a_slot;
   assign hs_entity = grant_b ? req_b_entity : req_a_entity;
   assign hs_ok     = (hs_slot >= 4'd1) && (hs_slot <= 4'd9);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ACCEPT;
         ci           <= 4'd1;
         prefer_a     <= 1'b1;
         bad_slot     <= 1'b0;
         frame_commit <= 1'b0;
         for (int k = 1; k <= 9; k++) begin
            shadow[k] <= UNUSED_WORD;
            active[k] <= UNUSED_WORD;
         end
      end else begin
         state        <= state_next;
         ci           <= ci_next;
         frame_commit <= last_copy;
         // Whoever was just served yields to the other on the next contention.
         if (hs)
            prefer_a <= grant_b;
         if (hs && hs_ok)
            shadow[hs_slot] <= hs_entity;
         if (state == COMMIT) begin
            active[ci] <= shadow[ci];
`ifdef SLOT_AUTOCLEAR_EN
            shadow[ci] <= UNUSED_WORD;
`endif
         end
         // The end-of-commit clear takes priority over a new error.
         bad_slot <= last_copy ? 1'b0 : (bad_slot || (hs && !hs_ok));
      end
   end

   assign entity_1      = active[1];
   assign entity_2      = active[2];
   assign entity_3      = active[3];
   assign entity_4      = active[4];
   assign entity_5      = active[5];
   assign entity_6      = active[6];
   assign entity_7      = active[7];
   assign entity_8_Flip = active[8];
   assign entity_9_Flip = active[9];
endmodule

// File: tb/tb_entity_slot_scheduler.sv
// tb_entity_slot_scheduler: self-checking bench for entity_slot_scheduler
module tb_entity_slot_scheduler;
   localparam logic [13:0] UW = 14'h3C00;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  counter_V = 10'd100;
   logic [9:0]  counter_H = 10'd7;
   logic        req_a_valid = 1'b0, req_b_valid = 1'b0;
   logic [3:0]  req_a_slot = '0, req_b_slot = '0;
   logic [13:0] req_a_entity = '0, req_b_entity = '0;
   logic        req_a_ready, req_b_ready, frame_commit, bad_slot;
   logic [13:0] entity_1, entity_2, entity_3, entity_4, entity_5, entity_6, entity_7;
   logic [13:0] entity_8_Flip, entity_9_Flip;
   logic [13:0] dut_ent [1:9];

   always #5 clk = ~clk;

   entity_slot_scheduler dut (
      .clk(clk), .reset(reset), .counter_V(counter_V), .counter_H(counter_H),
      .req_a_valid(req_a_valid), .req_a_slot(req_a_slot), .req_a_entity(req_a_entity),
      .req_a_ready(req_a_ready),
      .req_b_valid(req_b_valid), .req_b_slot(req_b_slot), .req_b_entity(req_b_entity),
      .req_b_ready(req_b_ready),
      .entity_1(entity_1), .entity_2(entity_2), .entity_3(entity_3), .entity_4(entity_4),
      .entity_5(entity_5), .entity_6(entity_6), .entity_7(entity_7),
      .entity_8_Flip(entity_8_Flip), .entity_9_Flip(entity_9_Flip),
      .frame_commit(frame_commit), .bad_slot(bad_slot)
   );

   assign dut_ent[1] = entity_1;
   assign dut_ent[2] = entity_2;
   assign dut_ent[3] = entity_3;
   assign dut_ent[4] = entity_4;
   assign dut_ent[5] = entity_5;
   assign dut_ent[6] = entity_6;
   assign dut_ent[7] = entity_7;
   assign dut_ent[8] = entity_8_Flip;
   assign dut_ent[9] = entity_9_Flip;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: shadow bank, active bank, and a snapshot of the shadow
   // taken at the trigger; commit cycle k publishes snapshot slot k.
   logic [13:0] m_sh [1:9];
   logic [13:0] m_act [1:9];
   logic [13:0] m_snap [1:9];
   int          m_phase;
   bit          m_last_b, m_bad, m_fc, e_ra, e_rb;

   typedef struct {
      bit av; logic [3:0] as; logic [13:0] ae;
      bit bv; logic [3:0] bs; logic [13:0] be;
      bit ra; bit rb; bit bad;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 1; k <= 9; k++) begin
         m_sh[k] = UW;
         m_act[k] = UW;
         m_snap[k] = UW;
      end
      m_phase = 0;
      m_last_b = 1'b1;
      m_bad = 1'b0;
      m_fc = 1'b0;
   endtask

   task automatic sample();
      @(negedge clk);
      if (reset || m_phase != 0) begin
         e_ra = 1'b0; e_rb = 1'b0;
      end else if (!req_a_valid && !req_b_valid) begin
         e_ra = 1'b1; e_rb = 1'b1;
      end else if (req_a_valid && req_b_valid) begin
         e_ra = m_last_b; e_rb = !m_last_b;
      end else begin
         e_ra = req_a_valid; e_rb = req_b_valid;
      end
      chk("req_a_ready", 32'(req_a_ready), 32'(e_ra));
      chk("req_b_ready", 32'(req_b_ready), 32'(e_rb));
      for (int k = 1; k <= 9; k++)
         chk($sformatf("entity_%0d", k), 32'(dut_ent[k]), 32'(m_act[k]));
      chk("frame_commit", 32'(frame_commit), 32'(m_fc));
      chk("bad_slot", 32'(bad_slot), 32'(m_bad));
   endtask

   task automatic model_write(input logic [3:0] s, input logic [13:0] e, input bit is_b);
      m_last_b = is_b;
      if (s >= 1 && s <= 9) m_sh[s] = e;
      else m_bad = 1'b1;
   endtask

   task automatic tick();
      bit trig;
      trig = (counter_V == 10'd480) && (counter_H == 10'd0);
      @(posedge clk);
      if (reset) model_reset();
      else begin
         m_fc = (m_phase == 9);
         if (m_phase == 0) begin
            if (e_ra && req_a_valid) model_write(req_a_slot, req_a_entity, 1'b0);
            else if (e_rb && req_b_valid) model_write(req_b_slot, req_b_entity, 1'b1);
            if (trig) begin
               m_snap = m_sh;
`ifdef SLOT_AUTOCLEAR_EN
               for (int k = 1; k <= 9; k++) m_sh[k] = UW;
`endif
               m_phase = 1;
            end
         end else begin
            m_act[m_phase] = m_snap[m_phase];
            if (m_phase == 9) begin
               m_phase = 0;
               m_bad = 1'b0;
            end else m_phase++;
         end
      end
      #1;
   endtask

   task automatic step();
      sample();
      tick();
   endtask

   task automatic drv(input bit av, input int as, input logic [13:0] ae,
                      input bit bv, input int bs, input logic [13:0] be);
      req_a_valid = av; req_a_slot = 4'(as); req_a_entity = ae;
      req_b_valid = bv; req_b_slot = 4'(bs); req_b_entity = be;
   endtask

   task automatic idle(input int n);
      drv(0, 0, '0, 0, 0, '0);
      repeat (n) step();
   endtask

   task automatic set_trig(input bit t);
      counter_V = t ? 10'd480 : 10'd100;
      counter_H = t ? 10'd0 : 10'd7;
   endtask

   // Trigger cycle T followed by T+1..T+10, checking commit timing by hand.
   task automatic do_commit();
      set_trig(1);
      step();
      set_trig(0);
      for (int k = 1; k <= 10; k++) begin
         sample();
         if (k <= 9) begin
            chk("readies_in_commit", {30'd0, req_a_ready, req_b_ready}, 32'd0);
            chk("no_early_commit_pulse", 32'(frame_commit), 32'd0);
         end else begin
            chk("frame_commit_T10", 32'(frame_commit), 32'd1);
            chk("bad_slot_T10", 32'(bad_slot), 32'd0);
         end
         tick();
      end
   endtask

   initial begin
      tbl[0] = '{1, 1, 14'h0101, 1, 2, 14'h0202, 1, 0, 0};
      tbl[1] = '{1, 1, 14'h0111, 1, 2, 14'h0212, 0, 1, 0};
      tbl[2] = '{1, 1, 14'h0121, 1, 2, 14'h0222, 1, 0, 0};
      tbl[3] = '{1, 1, 14'h0131, 1, 2, 14'h0232, 0, 1, 0};
      tbl[4] = '{0, 0, 14'h0000, 1, 3, 14'h0333, 0, 1, 0};
      tbl[5] = '{1, 4, 14'h0444, 1, 5, 14'h0555, 1, 0, 0};
      tbl[6] = '{0, 0, 14'h0000, 0, 0, 14'h0000, 1, 1, 0};
      tbl[7] = '{1, 0, 14'h0666, 0, 0, 14'h0000, 1, 0, 0};
      tbl[8] = '{0, 0, 14'h0000, 0, 0, 14'h0000, 1, 1, 1};
      tbl[9] = '{0, 0, 14'h0000, 1, 12, 14'h0777, 0, 1, 1};

      model_reset();
      @(posedge clk);
      #1;
      step();
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         drv(tbl[i].av, int'(tbl[i].as), tbl[i].ae, tbl[i].bv, int'(tbl[i].bs), tbl[i].be);
         sample();
         chk($sformatf("tbl%0d_ready_a", i), 32'(req_a_ready), 32'(tbl[i].ra));
         chk($sformatf("tbl%0d_ready_b", i), 32'(req_b_ready), 32'(tbl[i].rb));
         chk($sformatf("tbl%0d_bad_slot", i), 32'(bad_slot), 32'(tbl[i].bad));
         tick();
      end
      drv(0, 0, '0, 0, 0, '0);
      sample();
      chk("slots_before_commit", {18'd0, entity_1}, {18'd0, UW});
      tick();
      do_commit();
      sample();
      chk("entity_1_after_commit", 32'(entity_1), 32'h0121);
      chk("entity_4_after_commit", 32'(entity_4), 32'h0444);
      tick();

      reset = 1'b1;
      step();
      reset = 1'b0;
      do_commit();
      sample();
      for (int k = 1; k <= 9; k++)
         chk($sformatf("empty_frame_slot%0d", k), 32'(dut_ent[k]), 32'(UW));
      tick();

      drv(1, 3, 14'h1245, 0, 0, '0);
      step();
      idle(2);
      set_trig(1);
      step();
      set_trig(0);
      for (int k = 1; k <= 10; k++) begin
         sample();
         if (k <= 3) chk("entity_3_before", 32'(entity_3), 32'(UW));
         else chk("entity_3_after", 32'(entity_3), 32'h1245);
         if (k == 4) begin
            chk("entity_2_untouched", 32'(entity_2), 32'(UW));
            chk("entity_4_untouched", 32'(entity_4), 32'(UW));
         end
         tick();
      end

      drv(1, 5, 14'h2A5B, 0, 0, '0);
      do_commit();
      drv(0, 0, '0, 0, 0, '0);
      sample();
      chk("trigger_cycle_write", 32'(entity_5), 32'h2A5B);
      tick();

      drv(1, 4, 14'h1F0F, 0, 0, '0);
      step();
      idle(1);
      do_commit();
      do_commit();
      sample();
`ifdef SLOT_AUTOCLEAR_EN
      chk("autoclear_slot4", 32'(entity_4), 32'(UW));
`else
      chk("retain_slot4", 32'(entity_4), 32'h1F0F);
`endif
      tick();

      drv(1, 2, 14'h3111, 0, 0, '0);
      step();
      idle(1);
      set_trig(1);
      step();
      set_trig(0);
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         sample();
         chk("no_pulse_after_abort", 32'(frame_commit), 32'd0);
         if (k == 0)
            for (int j = 1; j <= 9; j++)
               chk($sformatf("abort_slot%0d", j), 32'(dut_ent[j]), 32'(UW));
         tick();
      end

      for (int i = 0; i < 3000; i++) begin
         req_a_valid  = $urandom_range(0, 2) != 0;
         req_a_slot   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(1, 9));
         req_a_entity = 14'($urandom);
         req_b_valid  = $urandom_range(0, 2) != 0;
         req_b_slot   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(1, 9));
         req_b_entity = 14'($urandom);
         counter_V    = ($urandom_range(0, 19) == 0) ? 10'd480 : 10'($urandom_range(0, 524));
         counter_H    = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(0, 799));
         reset        = $urandom_range(0, 399) == 0;
         step();
      end
      reset = 1'b0;
      set_trig(0);
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/entity_slot_scheduler.md
# entity_slot_scheduler

Frame-synchronous loader for the detection-combination unit's nine entity slots. It arbitrates entity-slot writes from two game-logic requesters into a shadow slot bank, then copies the shadow bank into the active slot registers one slot per cycle during vertical blanking. This prevents sprites from tearing mid-frame. It sits between the game-state logic and the DCU entity inputs and shares the VGA sync counters.

## Interface
Parameters:
- COMMIT_LINE, 480, counter_V value that triggers a commit
- COMMIT_PIXEL, 0, counter_H value that triggers a commit
- UNUSED_WORD, 14'h3C00, cleared slot value: ID 4'hF, orientation 0, location 8'h00

Ports:
- clk  in  1  pixel clock; counters advance once per clk
- reset  in  1  synchronous, active-high
- counter_V  in  10  VGA vertical counter
- counter_H  in  10  VGA horizontal counter
- req_a_valid  in  1  requester A write request
- req_a_slot  in  4  target slot for A, valid values 1..9
- req_a_entity  in  14  entity word for A: [13:10] ID, [9:8] orientation, [7:0] tile xxxx_yyyy
- req_a_ready  out  1  A write accepted this cycle when high together with valid
- req_b_valid, req_b_slot, req_b_entity, req_b_ready  same widths and meanings as A, for requester B
- entity_1 .. entity_7  out  14 each  active slots, non-flipped, to the DCU
- entity_8_Flip, entity_9_Flip  out  14 each  active flipped slots
- frame_commit  out  1  one-cycle pulse after the commit completes
- bad_slot  out  1  sticky flag: a handshake with slot 0 or 10..15 occurred since the last commit

## Operation
- The FSM has two states, ACCEPT and COMMIT, plus a 4-bit commit index `ci` (1..9).
- Trigger condition: state is ACCEPT and counter_V==COMMIT_LINE and counter_H==COMMIT_PIXEL.

ACCEPT state:
- Grant logic, at most one grant per cycle:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: round-robin; the requester not granted most recently wins. A wins first after reset.
- The granted requester's ready is high; the other ready is low. When neither is valid, both readies are high.
- On a handshake (valid && ready) with slot 1..9: shadow[slot] <= entity on the clock edge.
- On a handshake with an out-of-range slot: the write is discarded and bad_slot is set to 1.
- In the trigger cycle, grants and writes still occur as normal. On the edge, state moves to COMMIT with ci=1.

COMMIT state:
- Both readies are low.
- Each cycle: active[ci] <= shadow[ci], then ci increments.
- After ci=9 is copied: state returns to ACCEPT, frame_commit pulses, and bad_slot clears.
- If bad_slot is being set in the same cycle it is cleared, the clear wins.
- Slots 8 and 9 are copied unchanged; the DCU performs the flip.

Reset:
- All shadow and active slots become UNUSED_WORD.
- State becomes ACCEPT and ci=1; round-robin pointer favours A.
- bad_slot=0, frame_commit=0, both readies 0 in the reset cycle.
- Reset mid-commit abandons the copy; no slot keeps a partially committed frame.

## Timing
- Trigger in cycle T:
  - COMMIT occupies cycles T+1..T+9.
  - active slot k updates at the end of cycle T+k.
  - frame_commit is high in cycle T+10 only.
  - Readies return high in cycle T+10, subject to arbitration.
- A write to shadow is visible at the active outputs only after the next commit. The minimum is the trigger cycle itself, landing at the edge ending T+slot.
- The trigger is ignored while in COMMIT. Counters hold the trigger value for one cycle, so exactly one commit occurs per frame.
- All outputs are registered; there is no combinational path from req_* to entity_*.
- Readies are combinational from valid, state and the round-robin pointer.

## Configuration
- SLOT_AUTOCLEAR_EN defined:
  - In each commit cycle, shadow[ci] <= UNUSED_WORD at the same edge that copies it.
  - Entities not rewritten during a frame disappear at the next commit.
- SLOT_AUTOCLEAR_EN undefined:
  - The shadow retains its contents across commits.
  - Unwritten slots keep their last value indefinitely.

## Test plan
- Reset, then run one frame with no writes -> all nine entity outputs read 14'h3C00; frame_commit pulses once per frame at T+10.
- A writes slot 3 with 14'h1245 at line 100 -> entity_3 unchanged until commit; becomes 14'h1245 at the edge ending T+3; other slots stay 14'h3C00.
- A and B both valid for 4 cycles, targeting slots 1 and 2 -> grants alternate A,B,A,B; the ready of the ungranted requester is low each cycle.
- Write to slot 0 and slot 12 -> no slot changes; bad_slot=1 until the commit, cleared in cycle T+10.
- Trigger arrives while A is valid -> A handshakes in T; readies low in T+1..T+9; A's value appears on its slot at the commit.
- Assert reset at T+5 of a commit -> all slots read 14'h3C00 next cycle, no frame_commit pulse. With SLOT_AUTOCLEAR_EN, a slot not rewritten after a commit reads 14'h3C00 after the following commit.
